// File: rtl/pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// Hazard and forwarding controller for the 64-bit RISC-V pipeline. It tracks
// the instructions in flight after ID in a DEPTH-entry shift register:
// entry 0 = EX, entry 1 = MEM, ..., entry DEPTH-1 = WB.
// From that register it raises load-use stalls, branch flushes and the EX
// operand forward selects. It also keeps saturating stall/flush event counters.
//
// Parameters
//   REG_AW    register-index width
//   DEPTH     tracked stages after ID (EX..WB), legal range 3..6
//   BR_STAGE  entry index at which branches resolve (1 = MEM)
//   CNT_W     event counter width
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   id_*            fields of the instruction currently held in ID
//   branch_taken    branch in entry BR_STAGE resolved taken this cycle
//   stall           hold PC and IF/ID, bubble into ID/EX (combinational)
//   flush_front     clear IF/ID and entries 0..BR_STAGE (combinational)
//   fwd_a, fwd_b    EX operand source: 0 = regfile, k = entry k result
//   stall_cnt       saturating count of cycles with stall=1
//   flush_cnt       saturating count of cycles with flush_front=1
// -----------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned BR_STAGE = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     branch_taken,
  output logic                     stall,
  output logic                     flush_front,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int unsigned FW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             id_ent;
  logic [DEPTH-1:0]   writer;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               found_a, found_b;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = id_valid;
    id_ent.rs1      = id_rs1;
    id_ent.rs2      = id_rs2;
    id_ent.use1     = id_use_rs1;
    id_ent.use2     = id_use_rs2;
    id_ent.rd       = id_rd;
    id_ent.regwrite = id_regwrite;
    id_ent.memread  = id_memread;
  end

  // x0 is never a writer, so it can neither hazard nor forward.
  always_comb begin
    writer = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      writer[k] = ent_q[k].valid & ent_q[k].regwrite & (ent_q[k].rd != '0);
    end
  end

  // Load-use stall; a taken branch discards the dependent instruction anyway,
  // so the flush suppresses the stall.
  always_comb begin
    flush_front = branch_taken;
    stall = id_valid & writer[0] & ent_q[0].memread &
            ((id_use_rs1 & (id_rs1 == ent_q[0].rd)) |
             (id_use_rs2 & (id_rs2 == ent_q[0].rd))) &
            ~branch_taken;
  end

  // Forward selects: scan from the youngest older entry upward so the nearest
  // producer wins. A load only has its data once it reaches WB.
  always_comb begin
    fwd_a   = '0;
    fwd_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (ent_q[0].valid && writer[k] && !(ent_q[k].memread && (k != DEPTH - 1))) begin
        if (!found_a && ent_q[0].use1 && (ent_q[k].rd == ent_q[0].rs1)) begin
          fwd_a   = FW'(k);
          found_a = 1'b1;
        end
        if (!found_b && ent_q[0].use2 && (ent_q[k].rd == ent_q[0].rs2)) begin
          fwd_b   = FW'(k);
          found_b = 1'b1;
        end
      end
    end
  end

  // Next scoreboard contents: plain shift, then bubble entry 0 and, on a
  // flush, overwrite the shifted entries 1..BR_STAGE with bubbles.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ent_d[k] = '0;
    end
    ent_d[0] = (stall | flush_front | ~id_valid) ? '0 : id_ent;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      ent_d[k] = (flush_front && (k <= BR_STAGE)) ? '0 : ent_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_front && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Drives two scoreboards in parallel (DEPTH=3/BR_STAGE=1 and DEPTH=5/
// BR_STAGE=2) from the same ID stream and checks them against a reference
// model of the in-flight instruction list, plus directed scenario checks.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_a, flush_a, stall_b, flush_b;
  logic [1:0]  fa_a, fb_a;
  logic [2:0]  fa_b, fb_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;

  pipe_hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .BR_STAGE(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .stall(stall_a), .flush_front(flush_a), .fwd_a(fa_a), .fwd_b(fb_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipe_hazard_scoreboard #(.REG_AW(5), .DEPTH(5), .BR_STAGE(2), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .stall(stall_b), .flush_front(flush_b), .fwd_a(fa_b), .fwd_b(fb_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  // Reference model: list of in-flight instructions per instance, index 0 = EX.
  typedef struct {
    bit valid;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t   mdl [2][6];
  int     dep [2] = '{3, 5};
  int     brs [2] = '{1, 2};
  longint scnt [2];
  longint fcnt [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_writer(int i, int k);
    return mdl[i][k].valid && mdl[i][k].rw && (mdl[i][k].rd != 0);
  endfunction

  function automatic bit m_stall(int i);
    if (branch_taken || !id_valid) return 1'b0;
    if (!(m_writer(i, 0) && mdl[i][0].mr)) return 1'b0;
    return (id_use_rs1 && (int'(id_rs1) == mdl[i][0].rd)) ||
           (id_use_rs2 && (int'(id_rs2) == mdl[i][0].rd));
  endfunction

  // Nearest older producer whose result exists; loads only count in WB.
  function automatic int m_fwd(int i, bit second);
    int src;
    bit use_it;
    if (!mdl[i][0].valid) return 0;
    src    = second ? mdl[i][0].rs2 : mdl[i][0].rs1;
    use_it = second ? mdl[i][0].u2  : mdl[i][0].u1;
    if (!use_it) return 0;
    for (int k = 1; k < dep[i]; k++) begin
      if (m_writer(i, k) && !(mdl[i][k].mr && k < dep[i] - 1) && mdl[i][k].rd == src)
        return k;
    end
    return 0;
  endfunction

  // Let combinational outputs settle, then compare both instances to the model.
  task automatic look();
    #1;
    check("A.stall", stall_a, m_stall(0));
    check("A.flush", flush_a, branch_taken);
    check("A.fwd_a", fa_a, m_fwd(0, 0));
    check("A.fwd_b", fb_a, m_fwd(0, 1));
    check("A.stall_cnt", sc_a, scnt[0]);
    check("A.flush_cnt", fc_a, fcnt[0]);
    check("B.stall", stall_b, m_stall(1));
    check("B.flush", flush_b, branch_taken);
    check("B.fwd_a", fa_b, m_fwd(1, 0));
    check("B.fwd_b", fb_b, m_fwd(1, 1));
    check("B.stall_cnt", sc_b, scnt[1]);
    check("B.flush_cnt", fc_b, fcnt[1]);
  endtask

  // Clock edge: advance the model exactly as the pipeline would move.
  task automatic tick();
    ins_t bub;
    ins_t idi;
    bit   st;
    bub = '{default: 0};
    idi = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, u1: id_use_rs1, u2: id_use_rs2,
            rd: id_rd, rw: id_regwrite, mr: id_memread};
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int k = 0; k < 6; k++) mdl[i][k] = bub;
        scnt[i] = 0;
        fcnt[i] = 0;
      end else begin
        st = m_stall(i);
        if (st && scnt[i] < 64'hFFFF_FFFF) scnt[i]++;
        if (branch_taken && fcnt[i] < 64'hFFFF_FFFF) fcnt[i]++;
        for (int k = dep[i] - 1; k >= 1; k--) mdl[i][k] = mdl[i][k-1];
        if (branch_taken) for (int k = 1; k <= brs[i]; k++) mdl[i][k] = bub;
        mdl[i][0] = (st || branch_taken || !id_valid) ? bub : idi;
      end
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                     input int rd, input bit rw, input bit mr);
    id_valid    = v;
    id_rs1      = 5'(r1);
    id_rs2      = 5'(r2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    branch_taken = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 6; k++) mdl[i][k] = '{default: 0};
      scnt[i] = 0;
      fcnt[i] = 0;
    end
    @(negedge clk);
    do_reset();
    do_reset();

    // Reset state
    look();
    check("rst.stall", stall_a, 1'b0);
    check("rst.fwd_a", fa_a, 2'd0);
    check("rst.stall_cnt", sc_a, 32'd0);

    // 1: ld x5 ; add x6,x5,x1 -> one stall, then forward from WB
    drv(1, 1, 0, 1, 0, 5, 1, 1); look(); tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0); look();
    check("t1.stall", stall_a, 1'b1);
    tick(); look();
    check("t1.stall_once", stall_a, 1'b0);
    tick(); idle(); look();
    check("t1.fwd_wb", fa_a, 2'd2);
    check("t1.stall_cnt", sc_a, 32'd1);
    tick();

    // 2: add x5 ; sub x5,x5,x2 ; or x7,x5,x5 -> nearest producer (MEM)
    do_reset();
    drv(1, 0, 1, 1, 1, 5, 1, 0); look(); tick();
    drv(1, 5, 2, 1, 1, 5, 1, 0); look(); tick();
    drv(1, 5, 5, 1, 1, 7, 1, 0); look(); tick();
    idle(); look();
    check("t2.fwd_a", fa_a, 2'd1);
    check("t2.fwd_b", fb_a, 2'd1);
    tick();

    // 3: x0 never hazards or forwards, even from a load
    do_reset();
    drv(1, 0, 0, 1, 0, 0, 1, 1); look(); tick();
    drv(1, 0, 0, 1, 1, 3, 1, 0); look();
    check("t3.stall", stall_a, 1'b0);
    tick(); idle(); look();
    check("t3.fwd_a", fa_a, 2'd0);
    check("t3.fwd_b", fb_a, 2'd0);
    tick();

    // 4: taken branch over a load-use pair -> flush wins
    do_reset();
    drv(1, 1, 0, 1, 0, 5, 1, 1); look(); tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0); branch_taken = 1'b1; look();
    check("t4.stall", stall_a, 1'b0);
    check("t4.flush", flush_a, 1'b1);
    tick(); branch_taken = 1'b0; idle(); look();
    check("t4.flush_cnt", fc_a, 32'd1);
    check("t4.stall_cnt", sc_a, 32'd0);
    tick();

    // 5: reset during a stall clears everything
    do_reset();
    drv(1, 1, 0, 1, 0, 5, 1, 1); look(); tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0); reset = 1'b1; look(); tick();
    reset = 1'b0; look();
    check("t5.stall", stall_a, 1'b0);
    check("t5.stall_cnt", sc_a, 32'd0);
    tick(); idle(); look();
    check("t5.fwd_a", fa_a, 2'd0);
    tick();

    // 6: deep build: producer in entry 4 forwards; flush clears 0..2 only
    do_reset();
    drv(1, 1, 0, 1, 0, 5, 1, 0); look(); tick();
    drv(1, 2, 0, 1, 0, 5, 1, 0); look(); tick();
    idle(); look(); tick();
    branch_taken = 1'b1; look();
    check("t6.flush", flush_b, 1'b1);
    tick(); branch_taken = 1'b0;
    drv(1, 5, 0, 1, 0, 9, 1, 0); look(); tick();
    idle(); look();
    check("t6.fwd_a_e4", fa_b, 3'd4);
    check("t6.flush_cnt", fc_b, 32'd1);
    tick();

    // Randomized traffic over a small register range to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drv(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      branch_taken = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 49) == 0);
      look();
      tick();
    end
    reset = 1'b0;
    branch_taken = 1'b0;
    idle();
    look();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
